// File: rtl/muldiv_pkg.sv
// Types and constants shared by the divider, the multiplier and the HI/LO result mux.
package muldiv_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_LAT   = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage to divider handshake: operands and control in, busy/done flags and HI/LO out.
interface div_unit_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic             sign;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, sign, cancel, a, b,
    input  busy, done, dbz, hi, lo
  );

  modport slave (
    input  start, sign, cancel, a, b,
    output busy, done, dbz, hi, lo
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left one bit, subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The true difference is always below the divisor, so a WIDTH-bit wrapped subtract is exact.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    fits    = shifted >= {1'b0, divisor_i};
    diff    = shifted[WIDTH-1:0] - divisor_i;
    rem_o   = fits ? diff : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; quotient lands in LO, remainder in HI.
module div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             launch;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign abs_a  = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b  = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign launch = bus.start && !bus.cancel;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dbz_pend_d = dbz_pend_q;
    dbz_d      = dbz_q;

    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        if (launch) begin
          neg_quo_d = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d = bus.sign & bus.a[WIDTH-1];
          count_d   = CW'(WIDTH - 1);
          rem_d     = '0;
          dvs_d     = abs_b;
          // A zero divisor skips the iterations; quo holds the raw dividend for HI.
          if (bus.b == '0) begin
            quo_d      = bus.a;
            dbz_pend_d = 1'b1;
            state_d    = DIV_FIX;
          end else begin
            quo_d      = abs_a;
            dbz_pend_d = 1'b0;
            state_d    = DIV_RUN;
          end
        end
      end

      DIV_RUN: begin
        if (bus.cancel) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (count_q == '0) begin
            state_d = DIV_FIX;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end

      DIV_FIX: begin
        if (bus.cancel) begin
          state_d = DIV_IDLE;
        end else begin
          state_d = DIV_DONE;
          if (dbz_pend_q) begin
            lo_d  = '1;
            hi_d  = quo_q;
            dbz_d = 1'b1;
          end else begin
            lo_d  = neg_quo_q ? -quo_q : quo_q;
            hi_d  = neg_rem_q ? -rem_q : rem_q;
            dbz_d = 1'b0;
          end
        end
      end

      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DIV_IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dbz_pend_q <= dbz_pend_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.busy = (state_q == DIV_RUN) || (state_q == DIV_FIX);
  assign bus.done = (state_q == DIV_DONE);
  assign bus.dbz  = dbz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, divide-by-zero, cancel, reset.
module tb_div_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   check_count;
  int   err_count;
  int   seen_done;

  div_unit_if #(.WIDTH(DIV_WIDTH)) bus ();

  div_unit #(.WIDTH(DIV_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one operation; START is sampled on the next rising edge (edge 0).
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.sign  = sgn;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Launches an op and waits (bounded) for DONE; a nonzero repulse edge re-asserts START mid-flight.
  task automatic runOp(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                       input logic exp_dbz, input int repulse);
    int n;
    int busy_cnt;
    applyStimulus(sgn, a, b);
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < 60) begin
      if (bus.busy) busy_cnt++;
      if (repulse != 0 && n + 1 == repulse) begin
        bus.start = 1'b1;
        bus.sign  = 1'b0;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n++;
    end
    checkOutput({tag, "_latency"}, n, exp_lat);
    checkOutput({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    checkOutput({tag, "_lo"}, bus.lo, exp_lo);
    checkOutput({tag, "_hi"}, bus.hi, exp_hi);
    checkOutput({tag, "_dbz"}, {31'd0, bus.dbz}, {31'd0, exp_dbz});
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    check_count = 0;
    err_count   = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.sign    = 1'b0;
    bus.cancel  = 1'b0;
    bus.a       = '0;
    bus.b       = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_dbz", {31'd0, bus.dbz}, 32'd0);
    checkOutput("rst_hi", bus.hi, 32'd0);
    checkOutput("rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // DONE appears right after edge WIDTH+1 counted from the START edge.
    runOp("divu_100_7", 1'b0, 32'd100, 32'd7, DIV_LAT - 1, 32'd14, 32'd2, 1'b0, 0);
    runOp("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, DIV_LAT - 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    runOp("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, DIV_LAT - 1, 32'hFFFF_FFFD, 32'd1, 1'b0, 0);
    runOp("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT - 1, 32'h8000_0000, 32'd0, 1'b0, 0);
    runOp("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT - 1, 32'd0, 32'h8000_0000, 1'b0, 0);
    runOp("dbz", 1'b0, 32'h0000_1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 0);
    runOp("divu_53_5", 1'b0, 32'd53, 32'd5, DIV_LAT - 1, 32'd10, 32'd3, 1'b0, 0);
    runOp("busy_restart", 1'b0, 32'd100, 32'd7, DIV_LAT - 1, 32'd14, 32'd2, 1'b0, 5);
    runOp("divu_53_5b", 1'b0, 32'd53, 32'd5, DIV_LAT - 1, 32'd10, 32'd3, 1'b0, 0);

    // START with CANCEL in idle must not launch.
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    checkOutput("cancel_idle_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("cancel_idle_done", {31'd0, bus.done}, 32'd0);

    // START 100/7, re-pulse START 50/5 at edge 10, CANCEL at edge 20.
    applyStimulus(1'b0, 32'd100, 32'd7);
    seen_done = 0;
    for (int e = 1; e <= 21; e++) begin
      if (e == 10) begin
        bus.start = 1'b1;
        bus.a     = 32'd50;
        bus.b     = 32'd5;
      end
      if (e == 20) bus.cancel = 1'b1;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      if (bus.done) seen_done++;
      if (e == 20) checkOutput("cancel_busy", {31'd0, bus.busy}, 32'd0);
    end
    checkOutput("cancel_no_done", seen_done, 0);
    checkOutput("cancel_hi_kept", bus.hi, 32'd3);
    checkOutput("cancel_lo_kept", bus.lo, 32'd10);
    runOp("after_cancel", 1'b1, 32'hFFFF_FF9C, 32'd7, DIV_LAT - 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 0);

    // Asynchronous reset in the middle of RUN, checked between clock edges.
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("async_rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("async_rst_hi", bus.hi, 32'd0);
    checkOutput("async_rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runOp("after_reset", 1'b0, 32'd1003, 32'd10, DIV_LAT - 1, 32'd100, 32'd3, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
